// File: rtl/fc_classifier_if.sv
// rtl/fc_classifier_if.sv - feature stream, weight write and result bundle for fc_classifier
interface fc_classifier_if #(
    parameter int NUM_FEATURES = 225,
    parameter int NUM_CLASSES  = 4,
    parameter int FEAT_W       = 22,
    parameter int WT_W         = 8,
    parameter int ACC_W        = 40
);
    localparam int AW = $clog2(NUM_CLASSES * NUM_FEATURES);
    localparam int CW = $clog2(NUM_CLASSES);

    logic                     start_signal;
    logic                     feature_valid_in;
    logic signed [FEAT_W-1:0] feature_in;
    logic                     feature_done_in;
    logic                     wt_we;
    logic [AW-1:0]            wt_addr;
    logic signed [WT_W-1:0]   wt_data;

    logic                     score_valid;
    logic [CW-1:0]            score_class;
    logic signed [ACC_W-1:0]  score_out;
    logic                     pred_valid;
    logic [CW-1:0]            pred_class;
    logic                     done_signal;
    logic                     busy;
    logic                     count_error;

    modport master (
        output start_signal, feature_valid_in, feature_in, feature_done_in,
               wt_we, wt_addr, wt_data,
        input  score_valid, score_class, score_out, pred_valid, pred_class,
               done_signal, busy, count_error
    );

    modport slave (
        input  start_signal, feature_valid_in, feature_in, feature_done_in,
               wt_we, wt_addr, wt_data,
        output score_valid, score_class, score_out, pred_valid, pred_class,
               done_signal, busy, count_error
    );
endinterface

// File: rtl/fc_classifier.sv
// rtl/fc_classifier.sv - fully connected classification head, one MAC per cycle, argmax output
module fc_classifier #(
    parameter int NUM_FEATURES = 225,
    parameter int NUM_CLASSES  = 4,
    parameter int FEAT_W       = 22,
    parameter int WT_W         = 8,
    parameter int ACC_W        = 40
) (
    input  logic               clk,
    input  logic               rst,
    fc_classifier_if.slave     bus
);
    localparam int TOTAL = NUM_CLASSES * NUM_FEATURES;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = $clog2(NUM_CLASSES);
    localparam int IW    = $clog2(NUM_FEATURES);
    localparam int PW    = $clog2(NUM_FEATURES + 1);
    localparam int PRW   = FEAT_W + WT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_MAC,
        S_EMIT,
        S_RESULT
    } state_t;

    state_t state, state_next;

    // Feature buffer and weight memory carry no reset so weights survive rst
    logic signed [FEAT_W-1:0] fbuf [NUM_FEATURES];
    logic signed [WT_W-1:0]   wmem [TOTAL];

    logic [PW-1:0]            ptr;
    logic [IW-1:0]            idx;
    logic [CW-1:0]            cls;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  max_val;
    logic [CW-1:0]            max_cls;

    logic                     emit_valid;
    logic [CW-1:0]            emit_class;
    logic signed [ACC_W-1:0]  emit_score;
    logic                     result_valid;
    logic [CW-1:0]            result_class;
    logic                     result_done;
    logic                     err_flag;

    logic                     start_acc;
    logic                     feat_wr;
    logic                     go_error;
    logic                     frame_full;
    logic                     last_mac;
    logic                     last_cls;

    logic [AW-1:0]            wt_idx;
    logic signed [FEAT_W-1:0] feat_cur;
    logic signed [WT_W-1:0]   wt_cur;
    logic signed [PRW-1:0]    feat_ext;
    logic signed [PRW-1:0]    wt_ext;
    logic signed [PRW-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign frame_full = bus.feature_valid_in && (ptr == PW'(NUM_FEATURES - 1));
    assign last_mac   = (idx == IW'(NUM_FEATURES - 1));
    assign last_cls   = (cls == CW'(NUM_CLASSES - 1));

    // Operand fetch and full-precision product, sign-extended to accumulator width
    always_comb begin
        wt_idx   = AW'(cls) * AW'(NUM_FEATURES) + AW'(idx);
        feat_cur = fbuf[idx];
        wt_cur   = wmem[wt_idx];
        feat_ext = {{WT_W{feat_cur[FEAT_W-1]}}, feat_cur};
        wt_ext   = {{FEAT_W{wt_cur[WT_W-1]}}, wt_cur};
        prod     = feat_ext * wt_ext;
        prod_ext = {{(ACC_W - PRW){prod[PRW-1]}}, prod};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        feat_wr    = 1'b0;
        go_error   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_signal) begin
                    start_acc  = 1'b1;
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                feat_wr = bus.feature_valid_in;
                if (frame_full) begin
                    state_next = S_MAC;
                end else if (bus.feature_done_in) begin
                    go_error   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_MAC: begin
                if (last_mac) state_next = S_EMIT;
            end
            S_EMIT: begin
                state_next = last_cls ? S_RESULT : S_MAC;
            end
            S_RESULT: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Weight writes accepted only while idle; addresses past the matrix are dropped
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && bus.wt_we && bus.wt_addr < AW'(TOTAL))
            wmem[bus.wt_addr] <= bus.wt_data;
    end

    // Feature capture into the frame buffer
    always_ff @(posedge clk) begin
        if (!rst && feat_wr)
            fbuf[ptr[IW-1:0]] <= bus.feature_in;
    end

    // Counters, accumulator, running max and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            idx          <= '0;
            cls          <= '0;
            acc          <= '0;
            max_val      <= '0;
            max_cls      <= '0;
            emit_valid   <= 1'b0;
            emit_class   <= '0;
            emit_score   <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_done  <= 1'b0;
            err_flag     <= 1'b0;
        end else begin
            emit_valid   <= 1'b0;
            emit_class   <= '0;
            emit_score   <= '0;
            result_valid <= 1'b0;
            result_done  <= 1'b0;

            if (start_acc) begin
                ptr          <= '0;
                idx          <= '0;
                cls          <= '0;
                acc          <= '0;
                max_val      <= '0;
                max_cls      <= '0;
                result_class <= '0;
                err_flag     <= 1'b0;
            end

            if (feat_wr) ptr <= ptr + 1'b1;
            if (go_error) err_flag <= 1'b1;

            if (state == S_MAC) begin
                acc <= acc + prod_ext;
                idx <= last_mac ? '0 : idx + 1'b1;
            end

            if (state == S_EMIT) begin
                emit_valid <= 1'b1;
                emit_class <= cls;
                emit_score <= acc;
                // Strict compare keeps the lower index on ties; class 0 seeds the max
                if (cls == '0 || acc > max_val) begin
                    max_val <= acc;
                    max_cls <= cls;
                end
                acc <= '0;
                if (!last_cls) cls <= cls + 1'b1;
            end

            if (state == S_RESULT) begin
                result_valid <= 1'b1;
                result_done  <= 1'b1;
                result_class <= max_cls;
            end
        end
    end

    assign bus.score_valid = emit_valid;
    assign bus.score_class = emit_class;
    assign bus.score_out   = emit_score;
    assign bus.pred_valid  = result_valid;
    assign bus.pred_class  = result_class;
    assign bus.done_signal = result_done;
    assign bus.busy        = (state != S_IDLE);
    assign bus.count_error = err_flag;
endmodule

// File: tb/tb_fc_classifier.sv
// tb/tb_fc_classifier.sv - directed self-checking bench for fc_classifier
module tb_fc_classifier;
    localparam int NF = 225;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_classifier_if bus ();

    fc_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic signed [39:0] cap_s [8];
    int                 cap_t [8];
    logic [1:0]         cap_c [8];
    int                 n_score, n_pred, n_done, pred_t, n_done_alone;
    logic [1:0]         pred_c;

    task automatic idle_inputs();
        bus.start_signal     = 1'b0;
        bus.feature_valid_in = 1'b0;
        bus.feature_in       = '0;
        bus.feature_done_in  = 1'b0;
        bus.wt_we            = 1'b0;
        bus.wt_addr          = '0;
        bus.wt_data          = '0;
    endtask

    task automatic write_weights(input logic signed [7:0] w0, input logic signed [7:0] w1,
                                 input logic signed [7:0] w2, input logic signed [7:0] w3);
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < NF; i++) begin
                @(negedge clk);
                bus.wt_we   = 1'b1;
                bus.wt_addr = 10'(c * NF + i);
                bus.wt_data = (c == 0) ? w0 : (c == 1) ? w1 : (c == 2) ? w2 : w3;
            end
        end
        @(negedge clk);
        bus.wt_we = 1'b0;
    endtask

    // Feeds one full frame of constant features and records output pulses, k = cycles after T
    task automatic run_frame(input logic signed [21:0] fv, input bit poke_wt);
        n_score = 0; n_pred = 0; n_done = 0; pred_t = -1; pred_c = 'x; n_done_alone = 0;
        for (int j = 0; j < 8; j++) begin cap_s[j] = 'x; cap_t[j] = -1; cap_c[j] = 'x; end
        @(negedge clk);
        bus.start_signal = 1'b1;
        @(negedge clk);
        bus.start_signal = 1'b0;
        for (int i = 0; i < NF; i++) begin
            bus.feature_valid_in = 1'b1;
            bus.feature_in       = fv;
            if (poke_wt) begin
                bus.wt_we   = 1'b1;
                bus.wt_addr = 10'(i);
                bus.wt_data = -8'sd7;
            end
            @(negedge clk);
        end
        bus.feature_valid_in = 1'b0;
        bus.wt_we            = 1'b0;
        for (int k = 1; k <= 915; k++) begin
            @(negedge clk);
            if (bus.score_valid) begin
                if (n_score < 8) begin
                    cap_s[n_score] = bus.score_out;
                    cap_t[n_score] = k;
                    cap_c[n_score] = bus.score_class;
                end
                n_score++;
            end
            if (bus.pred_valid) begin
                n_pred++;
                pred_t = k;
                pred_c = bus.pred_class;
            end
            if (bus.done_signal) begin
                n_done++;
                if (!bus.pred_valid) n_done_alone++;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.score_valid !== 1'b0 || bus.score_out !== 40'sd0 || bus.score_class !== 2'd0) begin
            errors++; $display("FAIL reset_score: got v=%b c=%0d s=%0d want 0", bus.score_valid, bus.score_class, bus.score_out); end
        checks++; if (bus.pred_valid !== 1'b0 || bus.done_signal !== 1'b0 || bus.pred_class !== 2'd0 || bus.count_error !== 1'b0) begin
            errors++; $display("FAIL reset_pred: got pv=%b d=%b pc=%0d ce=%b want 0", bus.pred_valid, bus.done_signal, bus.pred_class, bus.count_error); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single_class(input string tag);
        logic signed [39:0] exp_s [4];
        exp_s = '{40'sd2250, 40'sd0, 40'sd0, 40'sd0};
        for (int c = 0; c < NC; c++) begin
            checks++; if (cap_s[c] !== exp_s[c]) begin errors++; $display("FAIL %s_score%0d: got %0d want %0d", tag, c, cap_s[c], exp_s[c]); end
            checks++; if (cap_t[c] !== (c + 1) * 226) begin errors++; $display("FAIL %s_time%0d: got %0d want %0d", tag, c, cap_t[c], (c + 1) * 226); end
            checks++; if (cap_c[c] !== 2'(c)) begin errors++; $display("FAIL %s_class%0d: got %0d want %0d", tag, c, cap_c[c], c); end
        end
        checks++; if (n_score !== 4) begin errors++; $display("FAIL %s_score_count: got %0d want 4", tag, n_score); end
        checks++; if (n_pred !== 1 || n_done !== 1 || n_done_alone !== 0) begin
            errors++; $display("FAIL %s_pulses: got pred=%0d done=%0d alone=%0d want 1 1 0", tag, n_pred, n_done, n_done_alone); end
        checks++; if (pred_t !== 905) begin errors++; $display("FAIL %s_pred_time: got %0d want 905", tag, pred_t); end
        checks++; if (pred_c !== 2'd0) begin errors++; $display("FAIL %s_pred_class: got %0d want 0", tag, pred_c); end
    endtask

    task automatic test_basic();
        write_weights(8'sd1, 8'sd0, 8'sd0, 8'sd0);
        run_frame(22'sd10, 1'b0);
        test_single_class("s1");
    endtask

    task automatic test_negative();
        logic signed [39:0] exp_s [4];
        exp_s = '{40'sd0, 40'sd0, 40'sd1125, -40'sd2250};
        write_weights(8'sd0, 8'sd0, -8'sd1, 8'sd2);
        run_frame(-22'sd5, 1'b0);
        for (int c = 0; c < NC; c++) begin
            checks++; if (cap_s[c] !== exp_s[c]) begin errors++; $display("FAIL s2_score%0d: got %0d want %0d", c, cap_s[c], exp_s[c]); end
        end
        checks++; if (pred_c !== 2'd2) begin errors++; $display("FAIL s2_pred_class: got %0d want 2", pred_c); end
        checks++; if (bus.pred_class !== 2'd2) begin errors++; $display("FAIL s2_pred_hold: got %0d want 2", bus.pred_class); end
    endtask

    task automatic test_tie();
        logic signed [39:0] exp_s [4];
        exp_s = '{40'sd0, 40'sd4725, 40'sd0, 40'sd4725};
        write_weights(8'sd0, 8'sd3, 8'sd0, 8'sd3);
        run_frame(22'sd7, 1'b0);
        for (int c = 0; c < NC; c++) begin
            checks++; if (cap_s[c] !== exp_s[c]) begin errors++; $display("FAIL s3_score%0d: got %0d want %0d", c, cap_s[c], exp_s[c]); end
        end
        checks++; if (pred_c !== 2'd1) begin errors++; $display("FAIL s3_pred_class: got %0d want 1", pred_c); end
    endtask

    task automatic test_short_frame();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.start_signal = 1'b1;
        @(negedge clk);
        bus.start_signal = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.feature_valid_in = 1'b1;
            bus.feature_in       = 22'sd1;
            @(negedge clk);
        end
        bus.feature_valid_in = 1'b0;
        bus.feature_done_in  = 1'b1;
        @(negedge clk);
        bus.feature_done_in  = 1'b0;
        checks++; if (bus.count_error !== 1'b1) begin errors++; $display("FAIL s4_count_error: got %b want 1", bus.count_error); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL s4_busy: got %b want 0", bus.busy); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.score_valid || bus.pred_valid || bus.done_signal) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL s4_no_pulses: got %0d want 0", pulses); end
        checks++; if (bus.count_error !== 1'b1) begin errors++; $display("FAIL s4_sticky: got %b want 1", bus.count_error); end
        bus.start_signal = 1'b1;
        @(negedge clk);
        bus.start_signal = 1'b0;
        checks++; if (bus.count_error !== 1'b0) begin errors++; $display("FAIL s4_clear: got %b want 0", bus.count_error); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL s4_rearm_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_extremes();
        logic signed [39:0] exp_v;
        exp_v = 40'sd60397977600;
        write_weights(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
        run_frame(-22'sd2097152, 1'b0);
        for (int c = 0; c < NC; c++) begin
            checks++; if (cap_s[c] !== exp_v) begin errors++; $display("FAIL s5_score%0d: got %0d want %0d", c, cap_s[c], exp_v); end
        end
        checks++; if (pred_c !== 2'd0) begin errors++; $display("FAIL s5_pred_class: got %0d want 0", pred_c); end
    endtask

    task automatic test_midreset_rerun();
        write_weights(8'sd1, 8'sd0, 8'sd0, 8'sd0);
        @(negedge clk);
        bus.start_signal = 1'b1;
        @(negedge clk);
        bus.start_signal = 1'b0;
        for (int i = 0; i < NF; i++) begin
            bus.feature_valid_in = 1'b1;
            bus.feature_in       = 22'sd10;
            @(negedge clk);
        end
        bus.feature_valid_in = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL s6_busy_mid: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL s6_rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.score_valid !== 1'b0 || bus.score_out !== 40'sd0 || bus.pred_valid !== 1'b0 ||
                      bus.done_signal !== 1'b0 || bus.pred_class !== 2'd0 || bus.count_error !== 1'b0) begin
            errors++; $display("FAIL s6_rst_outputs: got sv=%b s=%0d pv=%b d=%b pc=%0d ce=%b want 0",
                               bus.score_valid, bus.score_out, bus.pred_valid, bus.done_signal, bus.pred_class, bus.count_error); end
        rst = 1'b0;
        run_frame(22'sd10, 1'b1);
        test_single_class("s6a");
        run_frame(22'sd10, 1'b0);
        test_single_class("s6b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_tie();
        test_short_frame();
        test_extremes();
        test_midreset_rerun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Downstream consumer of Feature_Extractor. Buffers one frame of NUM_FEATURES signed 22-bit pooled features (15x15 = 225).
- Computes NUM_CLASSES dot products against a writable signed 8-bit weight memory, one MAC per cycle.
- Streams one score per class, then reports the argmax class with a done pulse.
- This is the classification head of the Mini_NPU pipeline.

Parameters:
NUM_FEATURES, 225, features per frame (15x15 pool output)
NUM_CLASSES, 4, number of output classes / weight rows
FEAT_W, 22, feature width (signed)
WT_W, 8, weight width (signed)
ACC_W, 40, accumulator and score width (signed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start_signal  in  1  arm block for a new frame (honoured only in IDLE)
feature_valid_in  in  1  feature_in valid this cycle
feature_in  in  FEAT_W  signed feature (Feature_Extractor final_result_out)
feature_done_in  in  1  upstream frame-done pulse (final_done_signal)
wt_we  in  1  weight write enable (honoured only in IDLE)
wt_addr  in  $clog2(NUM_CLASSES*NUM_FEATURES)  weight index = class*NUM_FEATURES + feature
wt_data  in  WT_W  signed weight
score_valid  out  1  one-cycle pulse per class score
score_class  out  $clog2(NUM_CLASSES)  class index of score_out
score_out  out  ACC_W  signed dot product
pred_valid  out  1  one-cycle pulse with final prediction
pred_class  out  $clog2(NUM_CLASSES)  argmax class
done_signal  out  1  one-cycle pulse, frame complete (same cycle as pred_valid)
busy  out  1  high in every state except IDLE
count_error  out  1  sticky: frame ended short; cleared by accepted start_signal or rst

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and running max cleared. Feature buffer and weight memory are not reset, so weights persist across rst.
- FSM states: IDLE -> COLLECT -> MAC -> EMIT -> (MAC for next class | RESULT) -> IDLE.
- IDLE:
  - wt_we writes weight[wt_addr] <= wt_data; out-of-range addresses are ignored.
  - start_signal: clear write pointer and count_error; next state COLLECT.
  - feature_valid_in is ignored.
- COLLECT:
  - Each feature_valid_in writes buf[ptr] and increments ptr. wt_we and start_signal are ignored.
  - Accepting feature NUM_FEATURES-1 (cycle T) -> MAC on T+1. A feature_done_in in the same cycle is a normal completion.
  - feature_done_in with fewer than NUM_FEATURES features accepted (counting a same-cycle valid): count_error=1 from the next cycle, return to IDLE. No score_valid, pred_valid or done_signal.
- MAC:
  - Index i runs 0..NUM_FEATURES-1, one per cycle: acc <= acc + buf[i]*weight[c*NUM_FEATURES+i].
  - Full-precision signed multiply (FEAT_W+WT_W bits), sign-extended to ACC_W. No saturation; ACC_W guarantees no overflow.
  - acc starts at 0 for each class.
- EMIT (1 cycle):
  - score_valid=1, score_class=c, score_out=final acc.
  - Update max on strict greater-than, so ties keep the lower index. Class 0 always initialises max.
  - c < NUM_CLASSES-1: c++, clear acc, -> MAC. Otherwise -> RESULT.
- RESULT (1 cycle): pred_valid=1, done_signal=1, pred_class=argmax; -> IDLE. pred_class holds its value until the next accepted start_signal or rst.
- Latency, with T = cycle the last feature is accepted:
  - score for class c: T+(c+1)*(NUM_FEATURES+1).
  - pred_valid/done_signal: T+NUM_CLASSES*(NUM_FEATURES+1)+1 (default T+905).
- score_out/score_class are 0 when score_valid=0.
- feature_valid_in outside COLLECT is dropped. No backpressure exists, so any upstream feature arriving in MAC/EMIT/RESULT is lost by design.
- rst mid-operation (any state): immediate return to IDLE with the reset values above. The next frame computes correctly with the retained weights.

Test Plan:
1. Class0 weights all 1, others 0; 225 features of 10 -> scores 2250,0,0,0 at T+226/452/678/904; pred_class=0 and done_signal at T+905, each exactly one cycle.
2. All features -5; class2 weights -1, class3 weights 2, classes 0/1 weights 0 -> scores 0,0,1125,-2250; pred_class=2.
3. Classes 1 and 3 share identical weights 3, others 0; features 7 -> scores 0,4725,0,4725; pred_class=1 (tie resolves to lower index).
4. start, 100 features, then feature_done_in -> count_error=1 next cycle, busy=0, no score_valid/pred_valid/done_signal. A following start clears count_error.
5. Extremes: all features -2097152, all weights -128 -> every score = 60397977600 with no wrap; pred_class=0.
6. rst asserted during class1 MAC -> all outputs 0 and busy=0 next cycle. wt_we during COLLECT is ignored (weight readback via a rerun of scenario 1 gives unchanged scores). Rerunning scenario 1 without rewriting weights gives identical results.
